datapost_pack: RTL

- Write-back packer for the matrix engine.
- Takes per-lane results from the MAC array (four 16-bit lanes) or from the sampler path (single 16-bit or 8-bit values).
- Reduces each value mod q by masking, packs values into 64-bit memory words, and presents them with incrementing addresses to the B/result memory write port over a valid/ready handshake.
- It is the inverse of the word-to-lane unpacking on the operand-read side.

---
 rtl/datapost_pack.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/datapost_pack.sv
// Write-back packer: masks MAC/sampler results, packs them into 64-bit words and
// hands them to the result-memory write port with incrementing word addresses.
module datapost_pack #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       q_mask,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_lane0,
   input  logic [15:0]       in_lane1,
   input  logic [15:0]       in_lane2,
   input  logic [15:0]       in_lane3,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [63:0]       out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic [ADDR_W-1:0] word_cnt,
   output logic              busy
);

   localparam logic [1:0] MODE_SER16 = 2'd1;
   localparam logic [1:0] MODE_SER8  = 2'd2;

   logic [63:0]       r_acc;
   logic [2:0]        r_cnt;
   logic              r_flush_pend;
   logic [1:0]        r_mode;
   logic              r_out_valid;
   logic [63:0]       r_out_data;
   logic [ADDR_W-1:0] r_out_addr;
   logic [ADDR_W-1:0] r_word_cnt;

   logic [15:0] w_lanes [4];
   logic [63:0] w_quad_word;
   logic [63:0] w_merged;
   logic        w_complete;
   logic [2:0]  w_cnt_after;
   logic        w_out_free;
   logic        w_drain;
   logic        w_accept;
   logic        w_in_ready;
   logic        w_emit_flush;

   assign w_lanes[0] = in_lane0;
   assign w_lanes[1] = in_lane1;
   assign w_lanes[2] = in_lane2;
   assign w_lanes[3] = in_lane3;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_quad_word[16*gi +: 16] = w_lanes[gi] & q_mask;
   end

   assign w_out_free   = !r_out_valid || out_ready;
   assign w_drain      = r_out_valid && out_ready;
   assign w_in_ready   = !start && !r_flush_pend && w_out_free;
   assign w_accept     = in_valid && w_in_ready;
   // A pending flush only ever exists with no beat in flight, since in_ready is low.
   assign w_emit_flush = r_flush_pend && w_out_free;

   // Current accumulator with this cycle's beat merged into its slot.
   always_comb begin
      w_merged   = r_acc;
      w_complete = 1'b1;
      case (r_mode)
         MODE_SER16: begin
            w_merged[{r_cnt[1:0], 4'b0000} +: 16] = in_lane0 & q_mask;
            w_complete = (r_cnt[1:0] == 2'd3);
         end
         MODE_SER8: begin
            w_merged[{r_cnt, 3'b000} +: 8] = in_lane0[7:0];
            w_complete = (r_cnt == 3'd7);
         end
         default: begin
            w_merged   = w_quad_word;
            w_complete = 1'b1;
         end
      endcase
   end

   always_comb begin
      w_cnt_after = r_cnt;
      if (w_accept) begin
         w_cnt_after = w_complete ? 3'd0 : r_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_acc        <= '0;
         r_cnt        <= '0;
         r_flush_pend <= 1'b0;
         r_mode       <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_addr   <= '0;
         r_word_cnt   <= '0;
      end else if (start) begin
         r_acc        <= '0;
         r_cnt        <= '0;
         r_flush_pend <= 1'b0;
         r_mode       <= mode;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_addr   <= base_addr;
         r_word_cnt   <= '0;
      end else begin
         if (w_drain) begin
            r_out_addr  <= r_out_addr + ADDR_W'(1);
            r_word_cnt  <= r_word_cnt + ADDR_W'(1);
            r_out_valid <= 1'b0;
         end

         if (w_accept) begin
            if (w_complete) begin
               r_out_data  <= w_merged;
               r_out_valid <= 1'b1;
               r_acc       <= '0;
               r_cnt       <= '0;
            end else begin
               r_acc <= w_merged;
               r_cnt <= w_cnt_after;
            end
         end

         if (w_emit_flush) begin
            r_out_data   <= r_acc;
            r_out_valid  <= 1'b1;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
         end else if (flush && (w_cnt_after != 3'd0)) begin
            r_flush_pend <= 1'b1;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_addr  = r_out_addr;
   assign word_cnt  = r_word_cnt;
   assign busy      = (r_cnt != 3'd0) || r_out_valid || r_flush_pend;

endmodule
